// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op at a time, checks alignment, drives the data_ram
// req/gnt/rvalid handshake and writes back extended load data. Optional LSU_TIMEOUT_EN macro.
module load_store_unit
`ifdef LSU_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 64)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic        ex_we_i,
  input  logic [2:0]  ex_op_i,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [4:0]  ex_rd_i,
  output logic        data_req_o,
  output logic [31:0] data_add_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  output logic [4:0]  data_rd_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic [4:0]  data_rd_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  // funct3[1:0] selects the access size; 011 and 11x fall back to word.
  function automatic size_t op_size(input logic [1:0] sz);
    case (sz)
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_req;
  logic [31:0] r_addr;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;
  logic [2:0]  r_op;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_misalign;

  size_t       w_ex_size;
  size_t       w_rsp_size;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;
  logic        w_accept;
  logic        w_bad;
  logic        w_wb_fire;
  logic        w_tmo_hit;

  assign w_ex_size  = op_size(ex_op_i[1:0]);
  assign w_rsp_size = op_size(r_op[1:0]);

  // Request-side decode: alignment, byte-enable code and lane replication.
  always_comb begin
    w_misaligned = 1'b0;
    w_be         = 4'b0001;
    w_wdata      = ex_wdata_i;
    case (w_ex_size)
      SZ_B: begin
        w_wdata = {4{ex_wdata_i[7:0]}};
        case (ex_addr_i[1:0])
          2'b00:   w_be = 4'b1000;
          2'b01:   w_be = 4'b1001;
          2'b10:   w_be = 4'b1010;
          default: w_be = 4'b1100;
        endcase
      end
      SZ_H: begin
        w_misaligned = ex_addr_i[0];
        w_wdata      = {2{ex_wdata_i[15:0]}};
        w_be         = ex_addr_i[1] ? 4'b0011 : 4'b0010;
      end
      default: begin
        w_misaligned = (ex_addr_i[1:0] != 2'b00);
      end
    endcase
  end

  // Response-side lane select; op[2] set means zero-extend.
  always_comb begin
    w_ld_byte = data_rdata_i[{r_addr[1:0], 3'b000} +: 8];
    w_ld_half = data_rdata_i[{r_addr[1], 4'b0000} +: 16];
    case (w_rsp_size)
      SZ_B:    w_ld_data = {{24{w_ld_byte[7] & ~r_op[2]}}, w_ld_byte};
      SZ_H:    w_ld_data = {{16{w_ld_half[15] & ~r_op[2]}}, w_ld_half};
      default: w_ld_data = data_rdata_i;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_timeout;
  logic             w_tmo_fire;

  assign w_tmo_hit  = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_tmo_fire = w_tmo_hit &
                      (((r_state == S_REQ) & ~data_gnt_i) |
                       ((r_state == S_WAIT_R) & ~data_rvalid_i));

  // Restarts on every state change, so REQ and WAIT_R each get a full budget.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_tmo_fire;
      if (w_state_nxt != r_state)
        r_tmo_cnt <= '0;
      else if (r_state != S_IDLE)
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_tmo_hit = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_bad       = 1'b0;
    w_wb_fire   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ex_valid_i) begin
          if (w_misaligned) begin
            w_bad = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (data_gnt_i) begin
          if (r_we) begin
            w_state_nxt = S_IDLE;
          end else if (data_rvalid_i) begin
            w_wb_fire   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_WAIT_R;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_R: begin
        if (data_rvalid_i) begin
          w_wb_fire   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: all control and datapath registers here are few and cheap, so every one is reset to a known 0.
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_op       <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_misalign <= w_bad;
      r_wb_valid <= w_wb_fire & (data_rd_i != 5'd0);
      if (w_wb_fire) begin
        r_wb_rd   <= data_rd_i;
        r_wb_data <= w_ld_data;
      end
      if (w_accept) begin
        r_req   <= 1'b1;
        r_addr  <= ex_addr_i;
        r_we    <= ex_we_i;
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_rd    <= ex_rd_i;
        r_op    <= ex_op_i;
      end else if ((r_state == S_REQ) && (w_state_nxt != S_REQ)) begin
        r_req <= 1'b0;
      end
    end
  end

  assign ex_ready_o   = (r_state == S_IDLE);
  assign data_req_o   = r_req;
  assign data_add_o   = r_addr;
  assign data_we_o    = r_we;
  assign data_be_o    = r_be;
  assign data_wdata_o = r_wdata;
  assign data_rd_o    = r_rd;
  assign wb_valid_o   = r_wb_valid;
  assign wb_rd_o      = r_wb_rd;
  assign wb_data_o    = r_wb_data;
  assign misalign_o   = r_misalign;

endmodule
